shift_seq_ctrl: RTL and testbench

Sequencer that turns the single-bit shift environment into a multi-bit logical shifter for DLX SLL/SRL-type operations. It accepts an operand, shift amount and direction through a start/busy/done handshake. It then drives the external one-bit shift unit for one clock per bit position, feeding the unit's output back into an internal register. It sits between the DLX control unit and the shift datapath.

---
 rtl/shift_seq_ctrl.sv | 85 ++++++++
 tb/tb_shift_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Multi-bit logical shifter sequencer driving an external
// one-bit shift unit, one bit position per clock.
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amount,
  input  logic             right,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] env_in,
  output logic             env_right,
  output logic             env_shift,
  input  logic [WIDTH-1:0] env_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = operand;
          cnt_d   = amount;
          dir_d   = right;
          state_d = (amount == '0) ? S_DONE
                                   : S_SHIFT;
        end
      end
      S_SHIFT: begin
        // The unit returns env_in shifted by one bit.
        data_d = env_out;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1))
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign env_shift = (state_q == S_SHIFT);
  assign env_right = dir_q;
  assign env_in    = data_q;
  assign result    = data_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural
// one-bit shift unit on the env_* side.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] operand;
  logic [4:0]  amount;
  logic        right;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] env_in;
  logic        env_right;
  logic        env_shift;
  logic [31:0] env_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // External one-bit shift unit: pass-through when not enabled.
  assign env_out = !env_shift ? env_in
                 : env_right  ? (env_in >> 1)
                 :              (env_in << 1);

  shift_seq_ctrl #(.WIDTH(32), .AMT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operand   (operand),
    .amount    (amount),
    .right     (right),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .env_in    (env_in),
    .env_right (env_right),
    .env_shift (env_shift),
    .env_out   (env_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag,
                          input logic [31:0] res);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_shen"}, 32'(env_shift), 32'd0);
    chk({tag, "_res"}, result, res);
  endtask

  // Issue one op and wait (bounded) for its done pulse.
  task automatic run_op(input string tag,
                        input logic [31:0] op,
                        input logic [4:0]  amt,
                        input logic        dir,
                        input logic [31:0] exp);
    int n;
    operand = op;
    amount  = amt;
    right   = dir;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    operand = 32'h5A5A_A5A5;
    amount  = 5'd3;
    right   = ~dir;
    n = 1;
    if (amt != 5'd0) begin
      chk({tag, "_shen"}, 32'(env_shift), 32'd1);
      chk({tag, "_dir"}, 32'(env_right), 32'(dir));
    end
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(amt) + 32'd1);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    idle_chk({tag, "_after"}, exp);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    operand = '0;
    amount  = '0;
    right   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      idle_chk("rst", 32'd0);
      tick();
    end

    // Left by 4 with per-cycle enable check.
    operand = 32'h0000_0001;
    amount  = 5'd4;
    right   = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("l4_shen", 32'(env_shift), 32'd1);
      chk("l4_nodone", 32'(done), 32'd0);
      tick();
    end
    chk("l4_done", 32'(done), 32'd1);
    chk("l4_res", result, 32'h0000_0010);
    tick();
    idle_chk("l4_idle", 32'h0000_0010);
    tick();
    idle_chk("l4_hold", 32'h0000_0010);

    run_op("r31", 32'h8000_0000, 5'd31, 1'b1,
           32'h0000_0001);
    run_op("z0", 32'hDEAD_BEEF, 5'd0, 1'b0,
           32'hDEAD_BEEF);
    // Back-to-back: issued in the IDLE cycle after done.
    run_op("b2b", 32'h0000_00A5, 5'd3, 1'b0,
           32'h0000_0528);
    run_op("r1", 32'h8000_0001, 5'd1, 1'b1,
           32'h4000_0000);

    // Start while busy is ignored.
    operand = 32'hFFFF_FFFF;
    amount  = 5'd8;
    right   = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    operand = 32'h0000_1234;
    amount  = 5'd0;
    right   = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_dir", 32'(env_right), 32'd1);
    for (int c = 4; c < 9; c++) begin
      chk("ign_nodone", 32'(done), 32'd0);
      tick();
    end
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_res", result, 32'h00FF_FFFF);
    tick();
    idle_chk("ign_idle", 32'h00FF_FFFF);

    // Reset aborts an op mid-shift.
    operand = 32'h0000_00F0;
    amount  = 5'd10;
    right   = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) begin
      chk("abt_nodone", 32'(done), 32'd0);
      tick();
    end
    chk("abt_mid", result, 32'h0000_0F00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_chk("abt_idle", 32'd0);
    chk("abt_dir", 32'(env_right), 32'd0);
    tick();
    idle_chk("abt_idle2", 32'd0);
    run_op("post", 32'h0000_0001, 5'd1, 1'b0,
           32'h0000_0002);

    // Reset and start together: start dropped.
    operand = 32'h0000_0077;
    amount  = 5'd2;
    right   = 1'b1;
    start   = 1'b1;
    reset   = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    idle_chk("rs_same", 32'd0);
    tick();
    idle_chk("rs_same2", 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
